// File: rtl/ifu_litebpu_pkg.sv
// Shared types for the IFU lite branch predictor.
// Holds the jalr rs1 fetch FSM encodings and default widths.
package ifu_litebpu_pkg;

    localparam int PC_SIZE     = 32;
    localparam int XLEN        = 32;
    localparam int RFIDX_WIDTH = 5;

    typedef enum logic [1:0] {
        BPU_ST_IDLE     = 2'd0,
        BPU_ST_DEP_WAIT = 2'd1,
        BPU_ST_RS1_RD   = 2'd2
    } bpu_st_e;

endpackage

// File: rtl/ifu_bpu_depchk.sv
// Dependency check for the jalr base register fetch.
// Ports: oitf_empty, ir_* (EXU IR state) in; x1dep, xndep, busy out.
module ifu_bpu_depchk #(
    parameter int RIDX_W = 5
) (
    input  logic              oitf_empty,
    input  logic              ir_valid,
    input  logic              ir_rden,
    input  logic [RIDX_W-1:0] ir_rdidx,
    input  logic              ir_rs1en,
    output logic              x1dep,
    output logic              xndep,
    output logic              busy
);

    logic ir_wr_x1;

    assign ir_wr_x1 = ir_valid & ir_rden
                    & (ir_rdidx == RIDX_W'(1));

    assign x1dep = ~oitf_empty | ir_wr_x1;
    // xn has no dedicated port: any IR occupant is treated as a hazard.
    assign xndep = ~oitf_empty | ir_valid;
    assign busy  = ir_valid & ir_rs1en;

endmodule

// File: rtl/ifu_litebpu.sv
// Lite branch predictor: predicted-taken and next-PC adder operands.
// Ports: pc, dec_* (mini-decoder), flush_req, oitf_empty, ir_* (EXU IR),
//        rf2bpu_x1/rs1 in; bpu2rf_rs1_ena, bpu_wait, prdt_* out.
// Macro IFU_BPU_BTFN_EN: backward-taken/forward-not-taken for bxx.
module ifu_litebpu
    import ifu_litebpu_pkg::*;
#(
    parameter int PC_W   = PC_SIZE,
    parameter int DW     = XLEN,
    parameter int RIDX_W = RFIDX_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   pc,
    input  logic              dec_i_valid,
    input  logic              dec_jal,
    input  logic              dec_jalr,
    input  logic              dec_bxx,
    input  logic [DW-1:0]     dec_bjp_imm,
    input  logic [RIDX_W-1:0] dec_jalr_rs1idx,
    input  logic              flush_req,
    input  logic              oitf_empty,
    input  logic              ir_valid,
    input  logic              ir_rden,
    input  logic [RIDX_W-1:0] ir_rdidx,
    input  logic              ir_rs1en,
    input  logic [DW-1:0]     rf2bpu_x1,
    input  logic [DW-1:0]     rf2bpu_rs1,
    output logic              bpu2rf_rs1_ena,
    output logic              bpu_wait,
    output logic              prdt_taken,
    output logic [PC_W-1:0]   prdt_pc_add_op1,
    output logic [PC_W-1:0]   prdt_pc_add_op2
);

    logic    x1dep;
    logic    xndep;
    logic    busy;
    logic    is_x0;
    logic    is_x1;
    logic    jalr_x1;
    logic    jalr_xn;
    logic    bxx_taken;
    logic    wait_x1;
    logic    wait_xn;
    logic    ena_c;
    bpu_st_e st;
    bpu_st_e st_nxt;

    ifu_bpu_depchk #(
        .RIDX_W (RIDX_W)
    ) u_depchk (
        .oitf_empty (oitf_empty),
        .ir_valid   (ir_valid),
        .ir_rden    (ir_rden),
        .ir_rdidx   (ir_rdidx),
        .ir_rs1en   (ir_rs1en),
        .x1dep      (x1dep),
        .xndep      (xndep),
        .busy       (busy)
    );

    assign is_x0 = (dec_jalr_rs1idx == RIDX_W'(0));
    assign is_x1 = (dec_jalr_rs1idx == RIDX_W'(1));

    assign jalr_x1 = dec_i_valid & dec_jalr & is_x1;
    assign jalr_xn = dec_i_valid & dec_jalr
                   & ~is_x0 & ~is_x1;

`ifdef IFU_BPU_BTFN_EN
    assign bxx_taken = dec_bjp_imm[DW-1];
`else
    assign bxx_taken = 1'b0;
`endif

    // x1 has a dedicated read path, so it only waits, no FSM.
    assign wait_x1 = jalr_x1 & x1dep & ~flush_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= BPU_ST_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt  = st;
        ena_c   = 1'b0;
        wait_xn = 1'b0;
        if (flush_req) begin
            st_nxt = BPU_ST_IDLE;
        end else begin
            unique case (st)
                BPU_ST_IDLE: begin
                    if (jalr_xn) begin
                        wait_xn = 1'b1;
                        if (xndep | busy) begin
                            st_nxt = BPU_ST_DEP_WAIT;
                        end else begin
                            ena_c  = 1'b1;
                            st_nxt = BPU_ST_RS1_RD;
                        end
                    end
                end
                BPU_ST_DEP_WAIT: begin
                    if (!dec_i_valid) begin
                        st_nxt = BPU_ST_IDLE;
                    end else begin
                        wait_xn = 1'b1;
                        if (!xndep && !busy) begin
                            ena_c  = 1'b1;
                            st_nxt = BPU_ST_RS1_RD;
                        end
                    end
                end
                BPU_ST_RS1_RD: begin
                    st_nxt = BPU_ST_IDLE;
                end
                default: begin
                    st_nxt = BPU_ST_IDLE;
                end
            endcase
        end
    end

    // Gate with rst_n so a held jalr cannot re-raise them during reset.
    assign bpu2rf_rs1_ena = rst_n & ena_c;
    assign bpu_wait       = rst_n & (wait_x1 | wait_xn);

    always_comb begin
        prdt_taken      = 1'b0;
        prdt_pc_add_op1 = pc;
        prdt_pc_add_op2 = '0;
        if (dec_i_valid) begin
            prdt_pc_add_op2 = PC_W'(dec_bjp_imm);
            unique case (1'b1)
                dec_jal: begin
                    prdt_taken = 1'b1;
                end
                dec_jalr: begin
                    prdt_taken = 1'b1;
                    if (is_x0) begin
                        prdt_pc_add_op1 = '0;
                    end else if (is_x1) begin
                        prdt_pc_add_op1 = PC_W'(rf2bpu_x1);
                    end else begin
                        prdt_pc_add_op1 = PC_W'(rf2bpu_rs1);
                    end
                end
                dec_bxx: begin
                    prdt_taken = bxx_taken;
                    if (!bxx_taken) begin
                        prdt_pc_add_op2 = PC_W'(4);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_litebpu.sv
// Directed self-checking bench for ifu_litebpu.
// Default widths (32/32/5); honours IFU_BPU_BTFN_EN if defined.
module tb_ifu_litebpu;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        dec_i_valid;
    logic        dec_jal;
    logic        dec_jalr;
    logic        dec_bxx;
    logic [31:0] dec_bjp_imm;
    logic [4:0]  dec_jalr_rs1idx;
    logic        flush_req;
    logic        oitf_empty;
    logic        ir_valid;
    logic        ir_rden;
    logic [4:0]  ir_rdidx;
    logic        ir_rs1en;
    logic [31:0] rf2bpu_x1;
    logic [31:0] rf2bpu_rs1;
    logic        bpu2rf_rs1_ena;
    logic        bpu_wait;
    logic        prdt_taken;
    logic [31:0] prdt_pc_add_op1;
    logic [31:0] prdt_pc_add_op2;

    int n_chk;
    int n_fail;

    ifu_litebpu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc              (pc),
        .dec_i_valid     (dec_i_valid),
        .dec_jal         (dec_jal),
        .dec_jalr        (dec_jalr),
        .dec_bxx         (dec_bxx),
        .dec_bjp_imm     (dec_bjp_imm),
        .dec_jalr_rs1idx (dec_jalr_rs1idx),
        .flush_req       (flush_req),
        .oitf_empty      (oitf_empty),
        .ir_valid        (ir_valid),
        .ir_rden         (ir_rden),
        .ir_rdidx        (ir_rdidx),
        .ir_rs1en        (ir_rs1en),
        .rf2bpu_x1       (rf2bpu_x1),
        .rf2bpu_rs1      (rf2bpu_rs1),
        .bpu2rf_rs1_ena  (bpu2rf_rs1_ena),
        .bpu_wait        (bpu_wait),
        .prdt_taken      (prdt_taken),
        .prdt_pc_add_op1 (prdt_pc_add_op1),
        .prdt_pc_add_op2 (prdt_pc_add_op2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec_none();
        dec_i_valid     = 1'b0;
        dec_jal         = 1'b0;
        dec_jalr        = 1'b0;
        dec_bxx         = 1'b0;
        dec_bjp_imm     = '0;
        dec_jalr_rs1idx = '0;
    endtask

    task automatic ir_idle();
        ir_valid = 1'b0;
        ir_rden  = 1'b0;
        ir_rdidx = '0;
        ir_rs1en = 1'b0;
    endtask

    task automatic dec_jalr_set(input logic [4:0] idx,
                                input logic [31:0] imm);
        dec_none();
        dec_i_valid     = 1'b1;
        dec_jalr        = 1'b1;
        dec_jalr_rs1idx = idx;
        dec_bjp_imm     = imm;
    endtask

    // Outputs of the ena/wait pair in one call.
    task automatic chk_hs(input string tag,
                          input logic e_ena,
                          input logic e_wait);
        chk({tag, ".ena"}, 32'(bpu2rf_rs1_ena), 32'(e_ena));
        chk({tag, ".wait"}, 32'(bpu_wait), 32'(e_wait));
    endtask

    logic [31:0] exp_tk_neg;
    logic [31:0] exp_op2_neg;

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        pc         = 32'h8000_0000;
        flush_req  = 1'b0;
        oitf_empty = 1'b1;
        rf2bpu_x1  = 32'h0000_1234;
        rf2bpu_rs1 = 32'h0000_abcd;
        dec_none();
        ir_idle();
`ifdef IFU_BPU_BTFN_EN
        exp_tk_neg  = 32'd1;
        exp_op2_neg = 32'hffff_fff8;
`else
        exp_tk_neg  = 32'd0;
        exp_op2_neg = 32'd4;
`endif

        #2;
        chk_hs("rst", 1'b0, 1'b0);
        chk("rst.tk", 32'(prdt_taken), 32'd0);
        chk("rst.op1", prdt_pc_add_op1, 32'h8000_0000);
        chk("rst.op2", prdt_pc_add_op2, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // jal
        dec_none();
        dec_i_valid = 1'b1;
        dec_jal     = 1'b1;
        dec_bjp_imm = 32'h10;
        #1;
        chk("jal.tk", 32'(prdt_taken), 32'd1);
        chk("jal.op1", prdt_pc_add_op1, 32'h8000_0000);
        chk("jal.op2", prdt_pc_add_op2, 32'h10);
        chk_hs("jal", 1'b0, 1'b0);
        tick();

        // bxx backward
        dec_none();
        dec_i_valid = 1'b1;
        dec_bxx     = 1'b1;
        dec_bjp_imm = 32'hffff_fff8;
        #1;
        chk("bneg.tk", 32'(prdt_taken), exp_tk_neg);
        chk("bneg.op1", prdt_pc_add_op1, 32'h8000_0000);
        chk("bneg.op2", prdt_pc_add_op2, exp_op2_neg);
        chk_hs("bneg", 1'b0, 1'b0);
        tick();

        // bxx forward: never taken
        dec_bjp_imm = 32'h8;
        #1;
        chk("bpos.tk", 32'(prdt_taken), 32'd0);
        chk("bpos.op2", prdt_pc_add_op2, 32'd4);
        tick();

        // non-bjp
        dec_none();
        dec_i_valid = 1'b1;
        dec_bjp_imm = 32'h20;
        pc          = 32'h8000_0100;
        #1;
        chk("nbj.tk", 32'(prdt_taken), 32'd0);
        chk("nbj.op1", prdt_pc_add_op1, 32'h8000_0100);
        chk("nbj.op2", prdt_pc_add_op2, 32'h20);
        tick();

        // jalr x1 with IR writing x1 for two cycles
        dec_jalr_set(5'd1, 32'h40);
        ir_valid = 1'b1;
        ir_rden  = 1'b1;
        ir_rdidx = 5'd1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk_hs($sformatf("x1dep%0d", i), 1'b0, 1'b1);
            chk("x1dep.tk", 32'(prdt_taken), 32'd1);
            tick();
        end
        ir_idle();
        #1;
        chk_hs("x1go", 1'b0, 1'b0);
        chk("x1go.op1", prdt_pc_add_op1, 32'h1234);
        chk("x1go.op2", prdt_pc_add_op2, 32'h40);
        // IR writing a different rd is no x1 hazard
        ir_valid = 1'b1;
        ir_rden  = 1'b1;
        ir_rdidx = 5'd2;
        #1;
        chk_hs("x1rd2", 1'b0, 1'b0);
        // outstanding writeback is
        ir_idle();
        oitf_empty = 1'b0;
        #1;
        chk_hs("x1oitf", 1'b0, 1'b1);
        oitf_empty = 1'b1;
        tick();

        // jalr x5, read port busy for three cycles
        dec_jalr_set(5'd5, 32'h80);
        ir_valid = 1'b1;
        ir_rs1en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_hs($sformatf("xnbusy%0d", i), 1'b0, 1'b1);
            tick();
        end
        ir_idle();
        #1;
        chk_hs("xnreq", 1'b1, 1'b1);
        tick();
        #1;
        chk_hs("xnrd", 1'b0, 1'b0);
        chk("xnrd.op1", prdt_pc_add_op1, 32'habcd);
        chk("xnrd.op2", prdt_pc_add_op2, 32'h80);
        chk("xnrd.tk", 32'(prdt_taken), 32'd1);
        tick();
        dec_none();
        #1;
        chk_hs("xnidle", 1'b0, 1'b0);
        tick();

        // jalr x5 flushed in DEP_WAIT
        dec_jalr_set(5'd5, 32'h80);
        ir_valid = 1'b1;
        #1;
        chk_hs("fl.idle", 1'b0, 1'b1);
        tick();
        flush_req = 1'b1;
        ir_valid  = 1'b0;
        #1;
        chk_hs("fl.req", 1'b0, 1'b0);
        tick();
        flush_req = 1'b0;
        dec_none();
        #1;
        chk_hs("fl.after", 1'b0, 1'b0);
        tick();

        // decode drop in DEP_WAIT
        dec_jalr_set(5'd7, 32'h0);
        ir_valid = 1'b1;
        tick();
        dec_none();
        ir_valid = 1'b0;
        #1;
        chk_hs("drop", 1'b0, 1'b0);
        tick();
        #1;
        chk_hs("drop2", 1'b0, 1'b0);

        // straight IDLE -> RS1_RD, then reset during RS1_RD
        dec_jalr_set(5'd5, 32'h80);
        #1;
        chk_hs("dir.req", 1'b1, 1'b1);
        tick();
        #1;
        chk_hs("dir.rd", 1'b0, 1'b0);
        chk("dir.op1", prdt_pc_add_op1, 32'habcd);
        rst_n = 1'b0;
        #1;
        chk_hs("rstmid", 1'b0, 1'b0);
        tick();
        dec_jalr_set(5'd0, 32'h44);
        rst_n = 1'b1;
        #1;
        chk_hs("x0", 1'b0, 1'b0);
        chk("x0.op1", prdt_pc_add_op1, 32'd0);
        chk("x0.op2", prdt_pc_add_op2, 32'h44);
        chk("x0.tk", 32'(prdt_taken), 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
